// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side fields, WB bypass inputs, pipeline control
// and the registered EX-stage fields with hazard counters.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              valid_ID;
    logic [DATA_W-1:0] pc_ID;
    logic [4:0]        rs_ID;
    logic [4:0]        rt_ID;
    logic [4:0]        rd_ID;
    logic              usesRs_ID;
    logic              usesRt_ID;
    logic [DATA_W-1:0] imm_ID;
    logic [DATA_W-1:0] readData1_ID;
    logic [DATA_W-1:0] readData2_ID;
    logic [1:0]        ctrlALUSrc1_ID;
    logic [1:0]        ctrlALUSrc2_ID;
    logic [3:0]        ctrlALUOp_ID;
    logic              ctrlRegWrite_ID;
    logic              ctrlMemRead_ID;
    logic              ctrlMemWrite_ID;
    logic              ctrlMemToReg_ID;
    logic              ctrlRegWrite_WB;
    logic [4:0]        rd_WB;
    logic [DATA_W-1:0] wbData_WB;
    logic              memStall;
    logic              flush;
    logic              stall_IF_ID;
    logic              valid_ID_EX;
    logic [DATA_W-1:0] pc_ID_EX;
    logic [4:0]        rs_ID_EX;
    logic [4:0]        rt_ID_EX;
    logic [4:0]        rd_ID_EX;
    logic [DATA_W-1:0] imm_ID_EX;
    logic [DATA_W-1:0] readData1_ID_EX;
    logic [DATA_W-1:0] readData2_ID_EX;
    logic [1:0]        ctrlALUSrc1_ID_EX;
    logic [1:0]        ctrlALUSrc2_ID_EX;
    logic [3:0]        ctrlALUOp_ID_EX;
    logic              ctrlRegWrite_ID_EX;
    logic              ctrlMemRead_ID_EX;
    logic              ctrlMemWrite_ID_EX;
    logic              ctrlMemToReg_ID_EX;
    logic [CNT_W-1:0]  loadUseCount;
    logic [CNT_W-1:0]  flushCount;

    modport slave (
        input  valid_ID, pc_ID, rs_ID, rt_ID, rd_ID, usesRs_ID, usesRt_ID, imm_ID,
               readData1_ID, readData2_ID, ctrlALUSrc1_ID, ctrlALUSrc2_ID, ctrlALUOp_ID,
               ctrlRegWrite_ID, ctrlMemRead_ID, ctrlMemWrite_ID, ctrlMemToReg_ID,
               ctrlRegWrite_WB, rd_WB, wbData_WB, memStall, flush,
        output stall_IF_ID, valid_ID_EX, pc_ID_EX, rs_ID_EX, rt_ID_EX, rd_ID_EX, imm_ID_EX,
               readData1_ID_EX, readData2_ID_EX, ctrlALUSrc1_ID_EX, ctrlALUSrc2_ID_EX,
               ctrlALUOp_ID_EX, ctrlRegWrite_ID_EX, ctrlMemRead_ID_EX, ctrlMemWrite_ID_EX,
               ctrlMemToReg_ID_EX, loadUseCount, flushCount
    );

    modport master (
        output valid_ID, pc_ID, rs_ID, rt_ID, rd_ID, usesRs_ID, usesRt_ID, imm_ID,
               readData1_ID, readData2_ID, ctrlALUSrc1_ID, ctrlALUSrc2_ID, ctrlALUOp_ID,
               ctrlRegWrite_ID, ctrlMemRead_ID, ctrlMemWrite_ID, ctrlMemToReg_ID,
               ctrlRegWrite_WB, rd_WB, wbData_WB, memStall, flush,
        input  stall_IF_ID, valid_ID_EX, pc_ID_EX, rs_ID_EX, rt_ID_EX, rd_ID_EX, imm_ID_EX,
               readData1_ID_EX, readData2_ID_EX, ctrlALUSrc1_ID_EX, ctrlALUSrc2_ID_EX,
               ctrlALUOp_ID_EX, ctrlRegWrite_ID_EX, ctrlMemRead_ID_EX, ctrlMemWrite_ID_EX,
               ctrlMemToReg_ID_EX, loadUseCount, flushCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, bubble insertion,
// branch flush, write-back read bypass and saturating hazard counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [1:0]        alu_src1;
        logic [1:0]        alu_src2;
        logic [3:0]        alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } ex_fields_t;

    ex_fields_t       ex_q, ex_d;
    logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             bypass1;
    logic             bypass2;

    // Counters stick at all-ones so a long run never reads back as small.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Hazard detection, WB bypass selects and the fetch stall request.
    always_comb begin
        load_use = ex_q.mem_read & ex_q.reg_write & (ex_q.rd != 5'd0) & bus.valid_ID &
                   ((bus.usesRs_ID & (bus.rs_ID == ex_q.rd)) |
                    (bus.usesRt_ID & (bus.rt_ID == ex_q.rd)));
        bypass1  = bus.ctrlRegWrite_WB & (bus.rd_WB != 5'd0) & (bus.rd_WB == bus.rs_ID);
        bypass2  = bus.ctrlRegWrite_WB & (bus.rd_WB != 5'd0) & (bus.rd_WB == bus.rt_ID);
        // A flush overrides the load-use hold so fetch can redirect.
        bus.stall_IF_ID = ~rst & (bus.memStall | (load_use & ~bus.flush));
    end

    // Next-state selection: freeze > flush > load-use bubble > decode load.
    always_comb begin
        ex_d           = ex_q;
        load_use_cnt_d = load_use_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        if (bus.memStall) begin
            ex_d = ex_q;
        end else if (bus.flush) begin
            ex_d = '0;
            if (bus.valid_ID) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
        end else if (load_use) begin
            ex_d           = '0;
            load_use_cnt_d = sat_inc(load_use_cnt_q);
        end else if (!bus.valid_ID) begin
            ex_d = '0;
        end else begin
            ex_d.valid      = 1'b1;
            ex_d.pc         = bus.pc_ID;
            ex_d.rs         = bus.rs_ID;
            ex_d.rt         = bus.rt_ID;
            ex_d.rd         = bus.rd_ID;
            ex_d.imm        = bus.imm_ID;
            ex_d.rdata1     = bypass1 ? bus.wbData_WB : bus.readData1_ID;
            ex_d.rdata2     = bypass2 ? bus.wbData_WB : bus.readData2_ID;
            ex_d.alu_src1   = bus.ctrlALUSrc1_ID;
            ex_d.alu_src2   = bus.ctrlALUSrc2_ID;
            ex_d.alu_op     = bus.ctrlALUOp_ID;
            // Writes to $0 are dropped here so EX forwarding never matches $0.
            ex_d.reg_write  = bus.ctrlRegWrite_ID & (bus.rd_ID != 5'd0);
            ex_d.mem_read   = bus.ctrlMemRead_ID;
            ex_d.mem_write  = bus.ctrlMemWrite_ID;
            ex_d.mem_to_reg = bus.ctrlMemToReg_ID;
        end
    end

    // Pipeline register and counters; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q           <= '0;
            load_use_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            ex_q           <= ex_d;
            load_use_cnt_q <= load_use_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    // Drive the registered EX-stage fields onto the bus.
    always_comb begin
        bus.valid_ID_EX        = ex_q.valid;
        bus.pc_ID_EX           = ex_q.pc;
        bus.rs_ID_EX           = ex_q.rs;
        bus.rt_ID_EX           = ex_q.rt;
        bus.rd_ID_EX           = ex_q.rd;
        bus.imm_ID_EX          = ex_q.imm;
        bus.readData1_ID_EX    = ex_q.rdata1;
        bus.readData2_ID_EX    = ex_q.rdata2;
        bus.ctrlALUSrc1_ID_EX  = ex_q.alu_src1;
        bus.ctrlALUSrc2_ID_EX  = ex_q.alu_src2;
        bus.ctrlALUOp_ID_EX    = ex_q.alu_op;
        bus.ctrlRegWrite_ID_EX = ex_q.reg_write;
        bus.ctrlMemRead_ID_EX  = ex_q.mem_read;
        bus.ctrlMemWrite_ID_EX = ex_q.mem_write;
        bus.ctrlMemToReg_ID_EX = ex_q.mem_to_reg;
        bus.loadUseCount       = load_use_cnt_q;
        bus.flushCount         = flush_cnt_q;
    end

endmodule
